// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared opcodes, FSM states and round-robin helpers for reg_arbiter
package reg_arb_pkg;
  localparam int N_REQ = 3;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_INR = 2'b10, OP_DCR = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ISSUE = 2'b01, S_ACK = 2'b10} state_e;
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin pick, searching from last+1
module rr_arbiter3 import reg_arb_pkg::*; (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       win,
  output logic             any
);
  logic [1:0] c0, c1, c2;
  always_comb begin
    c0 = next_idx(last);
    c1 = next_idx(c0);
    c2 = next_idx(c1);
    win = req[c0] ? c0 : req[c1] ? c1 : c2;
    any = |req;
  end
endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin arbiter issuing LOAD/INR/DCR to a shared register (IDLE->ISSUE->ACK).
// Define REG_ARB_SAT_EN to suppress INR at 0xFF and DCR at 0x00, pulsing sat instead.
module reg_arbiter import reg_arb_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] op,
  input  logic [8*N_REQ-1:0] data,
  input  logic [7:0]         reg_q,
  output logic [N_REQ-1:0]   gnt,
  output logic               reg_load,
  output logic               reg_inr,
  output logic               reg_dcr,
  output logic [7:0]         reg_data,
  output logic               busy,
  output logic               sat
);
  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [1:0] win_q, win_d, last_q, last_d, rr_win;
  logic [7:0] data_q, data_d;
  logic       rr_any, issue, sat_hit;
  rr_arbiter3 u_rr (.req(req), .last(last_q), .win(rr_win), .any(rr_any));
`ifdef REG_ARB_SAT_EN
  assign sat_hit = (op_q == OP_INR && reg_q == 8'hFF) || (op_q == OP_DCR && reg_q == 8'h00);
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign sat_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    win_d = win_q;
    last_d = last_q;
    data_d = data_q;
    if (state_q == S_IDLE) begin
      if (rr_any) begin
        state_d = S_ISSUE;
        win_d = rr_win;
        op_d = op_e'(op[{rr_win, 1'b0} +: 2]);
        data_d = data[{rr_win, 3'b000} +: 8];
      end
    end else if (state_q == S_ISSUE) begin
      state_d = S_ACK;
    end else begin
      state_d = S_IDLE;
      last_d = win_q;
    end
    // outputs are masked during rst so an aborted op never strobes or grants
    issue = !rst && state_q == S_ISSUE;
    reg_load = issue && op_q == OP_LOAD;
    reg_inr = issue && op_q == OP_INR && !sat_hit;
    reg_dcr = issue && op_q == OP_DCR && !sat_hit;
    sat = issue && sat_hit;
    gnt = (!rst && state_q == S_ACK) ? {{(N_REQ-1){1'b0}}, 1'b1} << win_q : '0;
    busy = !rst && state_q != S_IDLE;
    reg_data = rst ? 8'h00 : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= OP_NOP;
      win_q <= 2'd0;
      last_q <= 2'd2;
      data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      win_q <= win_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: randomized scoreboard bench for reg_arbiter with a transaction-level reference model
module tb_reg_arbiter;
`ifdef REG_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic [2:0] req, gnt;
  logic [5:0] op;
  logic [23:0] data;
  logic [7:0] reg_q, reg_data;
  logic reg_load, reg_inr, reg_dcr, busy, sat;
  always #5 clk = ~clk;
  reg_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data), .reg_q(reg_q),
    .gnt(gnt), .reg_load(reg_load), .reg_inr(reg_inr), .reg_dcr(reg_dcr),
    .reg_data(reg_data), .busy(busy), .sat(sat)
  );
  // the shared register the DUT commands
  logic [7:0] shreg = 8'h00;
  assign reg_q = shreg;
  always @(posedge clk) shreg <= reg_load ? reg_data : reg_inr ? shreg + 8'd1 : reg_dcr ? shreg - 8'd1 : shreg;
  typedef struct packed {
    logic [1:0] win;
    logic [2:0] strb;
    logic       sat;
    logic [7:0] data;
    logic [7:0] reg_after;
  } exp_t;
  exp_t exp_q[$];
  // reference model: one operation per 3 cycles, round-robin from last+1
  int mph = 0, mlast = 2, mwin = 0;
  logic [7:0] mreg = 8'h00, mnext = 8'h00, mdata = 8'h00;
  always @(posedge clk) begin
    exp_t e;
    int w, o;
    if (rst) begin
      mph <= 0;
      mlast <= 2;
      mdata <= 8'h00;
      exp_q.delete();
    end else if (mph == 0 && req != 3'b000) begin
      w = -1;
      for (int k = 1; k <= 3; k++) if (w < 0 && req[(mlast + k) % 3]) w = (mlast + k) % 3;
      o = int'(op[2*w +: 2]);
      e.win = 2'(w);
      e.data = data[8*w +: 8];
      e.sat = 1'b0;
      e.strb = 3'b000;
      e.reg_after = mreg;
      if (o == 1) begin
        e.strb = 3'b100;
        e.reg_after = e.data;
      end else if (o == 2) begin
        if (SAT && mreg == 8'hFF) e.sat = 1'b1;
        else begin e.strb = 3'b010; e.reg_after = mreg + 8'd1; end
      end else if (o == 3) begin
        if (SAT && mreg == 8'h00) e.sat = 1'b1;
        else begin e.strb = 3'b001; e.reg_after = mreg - 8'd1; end
      end
      exp_q.push_back(e);
      mnext <= e.reg_after;
      mdata <= e.data;
      mwin <= w;
      mph <= 1;
    end else if (mph == 1) begin
      mreg <= mnext;
      mph <= 2;
    end else if (mph == 2) begin
      mlast <= mwin;
      mph <= 0;
    end
  end
  // monitor / scoreboard
  int n_chk = 0, n_fail = 0, wait_cnt = 0;
  bit done = 1'b0;
  logic [2:0] p_strb = 3'b000;
  logic p_sat = 1'b0;
  logic [7:0] p_data = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
    if (rst) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_strobes", {reg_load, reg_inr, reg_dcr}, 0);
      chk("rst_sat", sat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reg_data", reg_data, 0);
      wait_cnt = 0;
    end else begin
      chk("strobe_onehot", $countones({reg_load, reg_inr, reg_dcr}) <= 1, 1);
      chk("busy", busy, mph != 0);
      if (mph == 0) chk("data_hold", reg_data, mdata);
      if (gnt != 3'b000) begin
        if (exp_q.size() == 0) chk("unexpected_gnt", gnt, 0);
        else begin
          e = exp_q.pop_front();
          chk("gnt", gnt, 3'b001 << e.win);
          chk("strobe", p_strb, e.strb);
          chk("sat", p_sat, e.sat);
          chk("issue_data", p_data, e.data);
          chk("reg_value", shreg, e.reg_after);
        end
        wait_cnt = 0;
      end else if (exp_q.size() != 0) begin
        wait_cnt++;
        if (wait_cnt > 2) begin
          chk("gnt_timeout", gnt, 3'b001 << exp_q[0].win);
          void'(exp_q.pop_front());
          wait_cnt = 0;
        end
      end
    end
    p_strb = {reg_load, reg_inr, reg_dcr};
    p_sat = sat;
    p_data = reg_data;
  end
  // requester driver
  logic [2:0] pend;
  logic [1:0] opr[3];
  logic [7:0] dr[3];
  assign req = pend;
  assign op = {opr[2], opr[1], opr[0]};
  assign data = {dr[2], dr[1], dr[0]};
  task automatic new_req(input int i);
    pend[i] = 1'b1;
    opr[i] = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: dr[i] = 8'h00;
      1: dr[i] = 8'hFF;
      default: dr[i] = 8'($urandom);
    endcase
  endtask
  task automatic step(input int pct, input bit wd);
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) pend[i] = 1'b0;
      else if (wd && pend[i] && mph == 1 && mwin == i && $urandom_range(0, 2) == 0) pend[i] = 1'b0;
      if (!pend[i] && !(mph != 0 && mwin == i && !gnt[i]) && $urandom_range(1, 100) <= pct) new_req(i);
    end
  endtask
  initial begin
    rst = 1'b1;
    pend = 3'b000;
    for (int i = 0; i < 3; i++) begin opr[i] = 2'b00; dr[i] = 8'h00; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) begin @(negedge clk); step(40, 1'b1); end
    repeat (60) begin @(negedge clk); step(100, 1'b0); end
    @(negedge clk);
    pend = 3'b000;
    repeat (4) @(negedge clk);
    pend = 3'b001;
    opr[0] = 2'b01;
    dr[0] = 8'h33;
    @(negedge clk);
    rst = 1'b1;
    pend = 3'b111;
    opr[1] = 2'b10;
    opr[2] = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) begin @(negedge clk); step(40, 1'b1); end
    repeat (20) begin @(negedge clk); step(0, 1'b0); end
    done = 1'b1;
  end
endmodule
